// File: rtl/debug_pkg.sv
// Shared definitions for the debug controller: FSM states, command bytes and frame geometry.
// DEBUG_CHECKSUM_EN adds a trailing XOR checksum byte to every frame.
package debug_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        STEP = 3'd2,
        SNAP = 3'd3,
        SEND = 3'd4
    } state_t;

    localparam logic [7:0]  CMD_RUN    = 8'h63;
    localparam logic [7:0]  CMD_STEP   = 8'h73;
    localparam logic [7:0]  CMD_DUMP   = 8'h64;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    localparam int WORD_BYTES       = 4;
    localparam int FRAME_WORDS      = 7;
    localparam int FRAME_DATA_BYTES = FRAME_WORDS * WORD_BYTES;
`ifdef DEBUG_CHECKSUM_EN
    localparam int FRAME_BYTES      = FRAME_DATA_BYTES + 1;
`else
    localparam int FRAME_BYTES      = FRAME_DATA_BYTES;
`endif
    localparam int IDX_W            = $clog2(FRAME_BYTES);

endpackage

// File: rtl/debug_tx_serializer.sv
// Streams the seven snapshot words MSB-first over a valid/ready byte interface.
// With DEBUG_CHECKSUM_EN a final byte carries the XOR of all data bytes.
module debug_tx_serializer
    import debug_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [FRAME_WORDS*32-1:0]   frame_words,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic                        done
);

    logic             active_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [7:0]       frame_byte [FRAME_DATA_BYTES];
    logic [7:0]       byte_sel;
    logic             handshake;
    logic             last_byte;

    // Byte 0 is the most significant byte of the first word.
    generate
        for (genvar gi = 0; gi < FRAME_DATA_BYTES; gi++) begin : g_bytes
            assign frame_byte[gi] = frame_words[(FRAME_DATA_BYTES-1-gi)*8 +: 8];
        end
    endgenerate

`ifdef DEBUG_CHECKSUM_EN
    logic [7:0] csum_reg;

    always_comb begin
        byte_sel = csum_reg;
        if (idx_reg < IDX_W'(FRAME_DATA_BYTES))
            byte_sel = frame_byte[idx_reg];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            csum_reg <= 8'h00;
        else if (start)
            csum_reg <= 8'h00;
        else if (handshake)
            csum_reg <= csum_reg ^ byte_sel;
    end
`else
    always_comb begin
        byte_sel = 8'h00;
        if (idx_reg < IDX_W'(FRAME_DATA_BYTES))
            byte_sel = frame_byte[idx_reg];
    end
`endif

    assign handshake = active_reg & tx_ready;
    assign last_byte = (idx_reg == IDX_W'(FRAME_BYTES-1));
    assign done      = handshake & last_byte;
    assign tx_valid  = active_reg;
    assign tx_data   = active_reg ? byte_sel : 8'h00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_reg <= 1'b0;
            idx_reg    <= '0;
        end else if (start) begin
            active_reg <= 1'b1;
            idx_reg    <= '0;
        end else if (handshake) begin
            if (last_byte) begin
                active_reg <= 1'b0;
                idx_reg    <= '0;
            end else begin
                idx_reg    <= idx_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/debug_unit.sv
// Debug controller: byte commands run/step the pipeline via pipe_en, HALT drains it,
// and a snapshot frame is streamed out. DEBUG_CHECKSUM_EN appends an XOR checksum byte.
module debug_unit
    import debug_pkg::*;
#(
    parameter int           B          = 32,
    parameter int           DRAIN      = 4,
    parameter logic [B-1:0] HALT_INSTR = B'(debug_pkg::HALT_INSTR),
    parameter logic [7:0]   CMD_RUN    = debug_pkg::CMD_RUN,
    parameter logic [7:0]   CMD_STEP   = debug_pkg::CMD_STEP,
    parameter logic [7:0]   CMD_DUMP   = debug_pkg::CMD_DUMP
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    input  logic [B-1:0] pc_if,
    input  logic [B-1:0] instr_if,
    input  logic [B-1:0] alu_ex,
    input  logic [B-1:0] alu_exmem,
    input  logic [B-1:0] mem_data_memwb,
    input  logic [B-1:0] wb_data,
    output logic         pipe_en,
    output logic         halted,
    output logic [31:0]  cycle_count
);

    localparam int DRAIN_W = $clog2(DRAIN + 1);

    state_t              state_reg;
    logic                pipe_en_reg;
    logic                halted_reg;
    logic [31:0]         cycle_count_reg;
    logic                drain_armed_reg;
    logic [DRAIN_W-1:0]  drain_cnt_reg;
    logic [B-1:0]        pc_sh_reg, instr_sh_reg, alu_ex_sh_reg;
    logic [B-1:0]        alu_exmem_sh_reg, mem_sh_reg, wb_sh_reg;
    logic [31:0]         count_sh_reg;

    logic                halt_seen;
    logic                halt_done;
    logic                ser_start;
    logic                ser_done;
    logic [FRAME_WORDS*32-1:0] frame_words;

    assign halt_seen = pipe_en_reg && !drain_armed_reg && (instr_if == HALT_INSTR);
    // The enabled cycle that takes the drain count from 1 to 0 is the last one.
    assign halt_done = pipe_en_reg && drain_armed_reg && (drain_cnt_reg == DRAIN_W'(1));

    assign rx_ready    = (state_reg == IDLE);
    assign pipe_en     = pipe_en_reg;
    assign halted      = halted_reg;
    assign cycle_count = cycle_count_reg;
    assign ser_start   = (state_reg == SNAP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            pipe_en_reg      <= 1'b0;
            halted_reg       <= 1'b0;
            cycle_count_reg  <= '0;
            drain_armed_reg  <= 1'b0;
            drain_cnt_reg    <= '0;
            pc_sh_reg        <= '0;
            instr_sh_reg     <= '0;
            alu_ex_sh_reg    <= '0;
            alu_exmem_sh_reg <= '0;
            mem_sh_reg       <= '0;
            wb_sh_reg        <= '0;
            count_sh_reg     <= '0;
        end else begin
            if (pipe_en_reg)
                cycle_count_reg <= cycle_count_reg + 32'd1;

            if (halt_seen) begin
                drain_armed_reg <= 1'b1;
                drain_cnt_reg   <= DRAIN_W'(DRAIN);
            end else if (pipe_en_reg && drain_armed_reg && drain_cnt_reg != '0) begin
                drain_cnt_reg   <= drain_cnt_reg - 1'b1;
            end

            if (halt_done)
                halted_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_RUN && !halted_reg) begin
                            state_reg   <= RUN;
                            pipe_en_reg <= 1'b1;
                        end else if (rx_data == CMD_STEP && !halted_reg) begin
                            state_reg   <= STEP;
                            pipe_en_reg <= 1'b1;
                        end else if (rx_data == CMD_DUMP) begin
                            state_reg   <= SNAP;
                        end
                    end
                end
                RUN: begin
                    if (halt_done) begin
                        state_reg   <= SNAP;
                        pipe_en_reg <= 1'b0;
                    end
                end
                STEP: begin
                    state_reg   <= SNAP;
                    pipe_en_reg <= 1'b0;
                end
                SNAP: begin
                    pc_sh_reg        <= pc_if;
                    instr_sh_reg     <= instr_if;
                    alu_ex_sh_reg    <= alu_ex;
                    alu_exmem_sh_reg <= alu_exmem;
                    mem_sh_reg       <= mem_data_memwb;
                    wb_sh_reg        <= wb_data;
                    count_sh_reg     <= cycle_count_reg;
                    state_reg        <= SEND;
                end
                SEND: begin
                    if (ser_done)
                        state_reg <= IDLE;
                end
                default: begin
                    state_reg   <= IDLE;
                    pipe_en_reg <= 1'b0;
                end
            endcase
        end
    end

    assign frame_words = {32'(pc_sh_reg), 32'(instr_sh_reg), 32'(alu_ex_sh_reg),
                          32'(alu_exmem_sh_reg), 32'(mem_sh_reg), 32'(wb_sh_reg),
                          count_sh_reg};

    debug_tx_serializer u_ser (
        .clk         (clk),
        .reset       (reset),
        .start       (ser_start),
        .frame_words (frame_words),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .done        (ser_done)
    );

endmodule

// File: tb/tb_debug_unit.sv
// Directed + randomized bench for debug_unit with a frame-level reference model.
// Honours DEBUG_CHECKSUM_EN for the expected frame length and trailing byte.
module tb_debug_unit;

    localparam int DRAIN = 4;
`ifdef DEBUG_CHECKSUM_EN
    localparam int FLEN = 29;
`else
    localparam int FLEN = 28;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] pc_if, instr_if, alu_ex, alu_exmem, mem_data_memwb, wb_data;
    logic        pipe_en;
    logic        halted;
    logic [31:0] cycle_count;

    int checks   = 0;
    int failures = 0;
    int en_seen  = 0;
    int en_base  = 0;
    int halt_at  = 0;
    logic [31:0] model_count;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    debug_unit dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .pc_if          (pc_if),
        .instr_if       (instr_if),
        .alu_ex         (alu_ex),
        .alu_exmem      (alu_exmem),
        .mem_data_memwb (mem_data_memwb),
        .wb_data        (wb_data),
        .pipe_en        (pipe_en),
        .halted         (halted),
        .cycle_count    (cycle_count)
    );

    always @(posedge clk) if (pipe_en === 1'b1) en_seen++;

    // The fetched instruction changes only while the pipeline advances.
    always @(negedge clk) begin
        if (pipe_en === 1'b1) begin
            if (halt_at > 0 && (en_seen - en_base) == halt_at - 1)
                instr_if = 32'hFFFF_FFFF;
            else
                instr_if = $urandom & 32'hFFFF_FFFE;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (rx_ready === 1'b1) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        rx_valid = 1'b0;
        check($sformatf("cmd_accept_%h", b), 32'(ok), 32'd1);
    endtask

    task automatic build_expected();
        logic [31:0] w [7];
        logic [7:0]  x;
        logic [7:0]  byt;
        w = '{pc_if, instr_if, alu_ex, alu_exmem, mem_data_memwb, wb_data, model_count};
        exp_q.delete();
        x = 8'h00;
        for (int i = 0; i < 7; i++) begin
            for (int b = 3; b >= 0; b--) begin
                byt = 8'((w[i] >> (8 * b)) & 32'hFF);
                exp_q.push_back(byt);
                x = x ^ byt;
            end
        end
`ifdef DEBUG_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // mode 0: always ready, 1: ready toggles 1,0,1,0..., 2: random ready
    task automatic recv_frame(input int mode, input int stop_after);
        int   n;
        logic built;
        logic prev_stall;
        logic [7:0] prev;
        n = 0;
        built = 1'b0;
        prev_stall = 1'b0;
        prev = 8'h00;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (tx_valid === 1'b1 && !built) begin
                build_expected();
                built = 1'b1;
                check("rx_ready_busy", 32'(rx_ready), 32'd0);
            end
            if (prev_stall)
                check($sformatf("tx_hold_b%0d", n), 32'(tx_data), 32'(prev));
            if (mode == 0)      tx_ready = 1'b1;
            else if (mode == 1) tx_ready = (cyc % 2 == 0);
            else                tx_ready = 1'($urandom_range(0, 1));
            prev_stall = (tx_valid === 1'b1) && !tx_ready;
            prev = tx_data;
            if (tx_valid === 1'b1 && tx_ready) begin
                check($sformatf("byte%0d", n), 32'(tx_data), 32'(exp_q[n]));
                n++;
            end
            tick();
            if (n == FLEN || (stop_after > 0 && n == stop_after)) break;
        end
        tx_ready = 1'b0;
        if (stop_after == 0) begin
            check("frame_len", 32'(n), 32'(FLEN));
            check("tx_idle_after", 32'(tx_valid), 32'd0);
        end
    endtask

    task automatic do_reset();
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        tick();
        model_count = 32'd0;
    endtask

    task automatic quiet_cycles(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (pipe_en !== 1'b0 || tx_valid !== 1'b0) bad++;
            tick();
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        pc_if = '0; instr_if = '0; alu_ex = '0; alu_exmem = '0; mem_data_memwb = '0; wb_data = '0;
        model_count = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pipe_en", 32'(pipe_en), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_cycle_count", cycle_count, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        @(negedge clk) reset = 1'b1;
        tick();
        check("rx_ready_after_rst", 32'(rx_ready), 32'd1);

        // single step, sink always ready
        pc_if = 32'h0000_0004;
        alu_ex = $urandom; alu_exmem = $urandom; mem_data_memwb = $urandom; wb_data = $urandom;
        en_base = en_seen;
        send_cmd(8'h73);
        model_count = model_count + 1;
        recv_frame(0, 0);
        check("step_en_cycles", 32'(en_seen - en_base), 32'd1);
        check("step_cycle_count", cycle_count, model_count);
        $display("step frame done count=%0d", model_count);

        // single step, sink toggling
        en_base = en_seen;
        send_cmd(8'h73);
        model_count = model_count + 1;
        recv_frame(1, 0);
        check("step2_en_cycles", 32'(en_seen - en_base), 32'd1);
        $display("toggled step frame done count=%0d", model_count);

        // unknown byte consumed with no side effects
        send_cmd(8'h78);
        quiet_cycles("unknown_quiet", 6);
        check("unknown_rx_ready", 32'(rx_ready), 32'd1);
        $display("unknown byte ignored");

        // run until HALT on the 10th enabled cycle
        do_reset();
        halt_at = 10;
        en_base = en_seen;
        send_cmd(8'h63);
        for (int i = 0; i < 200; i++) begin
            if (halted === 1'b1) break;
            tick();
        end
        check("run_halted", 32'(halted), 32'd1);
        model_count = 32'(halt_at + DRAIN);
        recv_frame(0, 0);
        check("run_en_cycles", 32'(en_seen - en_base), model_count);
        check("run_cycle_count", cycle_count, model_count);
        halt_at = 0;
        $display("run frame done count=%0d", model_count);

        // step after halt is ignored, dump still served
        en_base = en_seen;
        send_cmd(8'h73);
        quiet_cycles("halted_step_quiet", 6);
        check("halted_step_en", 32'(en_seen - en_base), 32'd0);
        send_cmd(8'h64);
        recv_frame(0, 0);
        check("dump_halted_sticky", 32'(halted), 32'd1);
        $display("dump after halt done count=%0d", model_count);

        // reset in the middle of a frame
        send_cmd(8'h64);
        recv_frame(0, 5);
        reset = 1'b0;
        #1;
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_halted", 32'(halted), 32'd0);
        check("midrst_cycle_count", cycle_count, 32'd0);
        @(negedge clk) reset = 1'b1;
        tick();
        model_count = 32'd0;
        check("midrst_rx_ready", 32'(rx_ready), 32'd1);
        send_cmd(8'h64);
        recv_frame(0, 0);
        $display("post-reset dump done count=%0d", model_count);

        // randomized steps with random sink back-pressure
        for (int t = 0; t < 6; t++) begin
            pc_if = $urandom; alu_ex = $urandom; alu_exmem = $urandom;
            mem_data_memwb = $urandom; wb_data = $urandom;
            en_base = en_seen;
            send_cmd(8'h73);
            model_count = model_count + 1;
            recv_frame(2, 0);
            check("rand_en_cycles", 32'(en_seen - en_base), 32'd1);
            check("rand_cycle_count", cycle_count, model_count);
            $display("random step %0d done count=%0d", t, model_count);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
Debug controller sitting directly downstream of the pipeline's observation outputs and upstream of its clock enable. It accepts single-byte commands from a byte-receive source, runs or single-steps the pipeline via pipe_en, and detects the HALT instruction and drains the pipeline. It snapshots selected stage values plus a cycle counter and streams them MSB-first as a byte frame over a valid/ready transmit interface, typically a UART TX.

Parameters:
B, 32, datapath/PC width of observed words
DRAIN, 4, enabled cycles still issued after HALT is sampled in IF (>=1)
HALT_INSTR, 32'hFFFFFFFF, instruction word that stops the program
CMD_RUN, 8'h63, 'c': continuous run
CMD_STEP, 8'h73, 's': single step
CMD_DUMP, 8'h64, 'd': send snapshot without advancing

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rx_data  in  8  command byte
rx_valid  in  1  command byte present
rx_ready  out  1  command accepted when rx_valid&rx_ready
tx_data  out  8  frame byte
tx_valid  out  1  frame byte present
tx_ready  in  1  sink accepts byte
pc_if  in  B  incremented PC, IF stage
instr_if  in  B  fetched instruction, IF stage
alu_ex  in  B  ALU result, EX
alu_exmem  in  B  ALU result, EX/MEM latch
mem_data_memwb  in  B  memory read data, MEM/WB latch
wb_data  in  B  write-back mux output
pipe_en  out  1  pipeline clock enable
halted  out  1  program finished; sticky until reset
cycle_count  out  32  number of enabled cycles issued

Behaviour:
- Reset (reset=0, async): state IDLE; pipe_en=0, tx_valid=0, tx_data=0, halted=0, cycle_count=0, drain logic disarmed, byte index 0, shadow regs 0.
- rx_ready=1 only in IDLE; otherwise 0. Commands are never lost and never consumed outside IDLE.
- IDLE, on rx handshake:
  - CMD_RUN goes to RUN.
  - CMD_STEP goes to STEP.
  - CMD_DUMP goes to SNAP.
  - Any other byte is consumed and ignored.
  - If halted=1, RUN and STEP are consumed and ignored; DUMP is still served.
- RUN: pipe_en=1 every cycle until halt completes.
- STEP: pipe_en=1 for exactly one cycle, then SNAP.
- Every cycle with pipe_en=1 increments cycle_count (mod 2^32, wraps to 0).
- Halt: an enabled cycle k with instr_if==HALT_INSTR and drain disarmed arms the drain counter at DRAIN.
  - Each later enabled cycle decrements the counter.
  - The enabled cycle that brings it to 0 is the last one; halted=1 from the next cycle.
  - Enabled cycles k+1..k+DRAIN still occur.
  - The drain counter persists across STEP commands.
  - In RUN, halt completion transitions to SNAP.
- SNAP (1 cycle, pipe_en=0): capture the six stage inputs and cycle_count into shadow registers, then go to SEND.
- SEND: frame of 28 bytes, words in this order: pc_if, instr_if, alu_ex, alu_exmem, mem_data_memwb, wb_data, cycle_count; each word MSB-first.
  - tx_valid=1 throughout.
  - tx_data is held stable while tx_valid&!tx_ready.
  - The byte index advances only on a handshake; back-to-back bytes are allowed.
  - After the last handshake, return to IDLE; tx_valid=0 the following cycle.
- Reset mid-frame or mid-run: everything is cleared immediately and the frame is abandoned.

Optional Feature:
DEBUG_CHECKSUM_EN:
- Defined: one extra byte is appended, the XOR of all 28 frame bytes, so the frame is 29 bytes; the handshake rules are unchanged.
- Undefined: the frame is 28 bytes and no checksum logic exists.

Decomposition:
- Shared package debug_pkg holds:
  - the state encoding (IDLE, RUN, STEP, SNAP, SEND);
  - the CMD_* values and HALT_INSTR;
  - FRAME_WORDS=7 and FRAME_BYTES (28, or 29 with checksum).
- Sub-module debug_tx_serializer: loads the shadow words, owns the byte index, the tx_valid/tx_data handshake and the optional checksum; it reports done to the FSM.

Test Plan:
- Reset asserted, then released: pipe_en=0, tx_valid=0, cycle_count=0, halted=0; rx_ready=1 on the first cycle after release.
- 's' with pc_if=32'h00000004 and tx_ready=1: pipe_en high for exactly 1 cycle; 28 bytes follow; bytes 0-3 = 00 00 00 04; bytes 24-27 = 00 00 00 01.
- Same step with tx_ready toggling 1,0,1,0: each byte stays stable while stalled; exactly 28 handshakes, no duplicates or drops.
- 'c' with instr_if=FFFFFFFF on the 10th enabled cycle, DRAIN=4: 14 enabled cycles total; halted=1; frame cycle_count bytes = 00 00 00 0E. A later 's' is ignored; 'd' returns a frame with the same count.
- Byte 'x' in IDLE: consumed in 1 cycle; no pipe_en and no tx activity.
- Reset asserted after the 5th frame byte: tx_valid=0 asynchronously; after release the state is IDLE and a new 'd' sends a full 28-byte frame from byte 0.
